// File: rtl/regfile_scoreboard_if.sv
// Bus interface for regfile_scoreboard: writeback, issue and read-port signals.
// master drives writeback/issue/read addresses; slave is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0]        ctrl_writeReg;
    logic [DATA_WIDTH-1:0]        data_writeReg;
    logic                         ctrl_issueEnable;
    logic [ADDR_WIDTH-1:0]        ctrl_issueReg;
    logic                         issue_ready;
    logic [NUM_RD*ADDR_WIDTH-1:0] ctrl_readReg;
    logic [NUM_RD*DATA_WIDTH-1:0] data_readReg;
    logic [NUM_RD-1:0]            busy_readReg;
    logic                         err_underflow;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
        input  issue_ready, data_readReg, busy_readReg, err_underflow
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
        output issue_ready, data_readReg, busy_readReg, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register pending-write counter (scoreboard).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int CNT_WIDTH  = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                clock,
    input  logic                ctrl_reset_n,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q  [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_d  [DEPTH];
    logic                  err_q;
    logic                  err_d;

    logic                  zero_wr_s;
    logic                  zero_iss_s;
    logic                  wr_en_s;
    logic                  same_reg_s;
    logic [CNT_WIDTH-1:0]  iss_cnt_s;
    logic [CNT_WIDTH-1:0]  iss_post_s;
    logic [CNT_WIDTH-1:0]  wr_cnt_s;
    logic                  issue_ready_s;
    logic                  iss_en_s;
    logic                  underflow_s;
    logic [DATA_WIDTH-1:0] rd_data_s [NUM_RD];
    logic                  rd_busy_s [NUM_RD];

    assign zero_wr_s  = (ZERO_REG != 0) && (bus.ctrl_writeReg == REG_ZERO);
    assign zero_iss_s = (ZERO_REG != 0) && (bus.ctrl_issueReg == REG_ZERO);
    assign wr_en_s    = bus.ctrl_writeEnable && !zero_wr_s;
    assign same_reg_s = wr_en_s && (bus.ctrl_writeReg == bus.ctrl_issueReg);

    // Readiness looks at the count after this cycle's writeback, so a retiring write frees a slot at once.
    assign iss_cnt_s     = cnt_q[bus.ctrl_issueReg];
    assign iss_post_s    = (same_reg_s && (iss_cnt_s != CNT_ZERO)) ? (iss_cnt_s - CNT_ONE) : iss_cnt_s;
    assign issue_ready_s = zero_iss_s || (iss_post_s != CNT_MAX);
    assign iss_en_s      = bus.ctrl_issueEnable && issue_ready_s && !zero_iss_s;

    // A same-register issue balances the write, so a zero count there is not an underflow.
    assign wr_cnt_s    = cnt_q[bus.ctrl_writeReg];
    assign underflow_s = wr_en_s && (wr_cnt_s == CNT_ZERO) && !(iss_en_s && same_reg_s);
    assign err_d       = err_q || underflow_s;

    // Next pending count per register from accepted issue and effective writeback.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_en_s && (bus.ctrl_issueReg == ADDR_WIDTH'(i)) &&
                wr_en_s && (bus.ctrl_writeReg == ADDR_WIDTH'(i))) begin
                cnt_d[i] = cnt_q[i];
            end else if (iss_en_s && (bus.ctrl_issueReg == ADDR_WIDTH'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (wr_en_s && (bus.ctrl_writeReg == ADDR_WIDTH'(i)) && (cnt_q[i] != CNT_ZERO)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Scoreboard counters and sticky underflow flag.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Register storage written on effective writeback.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[bus.ctrl_writeReg] <= bus.data_writeReg;
        end else begin
            regs_q <= regs_q;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [CNT_WIDTH-1:0]  cnt_s;
        logic                  zero_s;
        logic                  byp_s;

        assign addr_s = bus.ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign cnt_s  = cnt_q[addr_s];
        assign zero_s = (ZERO_REG != 0) && (addr_s == REG_ZERO);
`ifdef REGFILE_BYPASS_EN
        assign byp_s  = wr_en_s && (addr_s == bus.ctrl_writeReg);
`else
        assign byp_s  = 1'b0;
`endif

        // Read port: hardwired zero, forwarded writeback, or stored state.
        always_comb begin
            if (zero_s) begin
                rd_data_s[k] = {DATA_WIDTH{1'b0}};
                rd_busy_s[k] = 1'b0;
            end else if (byp_s) begin
                rd_data_s[k] = bus.data_writeReg;
                rd_busy_s[k] = (cnt_s > CNT_ONE);
            end else begin
                rd_data_s[k] = regs_q[addr_s];
                rd_busy_s[k] = (cnt_s != CNT_ZERO);
            end
        end
    end

    // Pack per-port results onto the flat bus vectors.
    always_comb begin
        bus.data_readReg = {(NUM_RD*DATA_WIDTH){1'b0}};
        bus.busy_readReg = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            bus.data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_s[k];
            bus.busy_readReg[k]                          = rd_busy_s[k];
        end
    end

    assign bus.issue_ready   = issue_ready_s;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against a behavioural register/count model.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int CW = 2;
    localparam int DEPTH = 32;
    localparam int MAXC = 3;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .CNT_WIDTH(CW), .ZERO_REG(1)
    ) dut (
        .clock(clock),
        .ctrl_reset_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_reg [DEPTH];
    int          m_cnt [DEPTH];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int post_cnt(input int r);
        int c;
        c = m_cnt[r];
        if (bus.ctrl_writeEnable && int'(bus.ctrl_writeReg) == r && r != 0 && c > 0) c = c - 1;
        return c;
    endfunction

    function automatic bit exp_ready();
        int r;
        r = int'(bus.ctrl_issueReg);
        if (r == 0) return 1'b1;
        return post_cnt(r) != MAXC;
    endfunction

    // Behavioural model: stored values, pending counts, sticky underflow.
    always @(posedge clock or negedge rst_n) begin : model
        int wr;
        int ir;
        bit wh;
        bit acc;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i] <= 32'h0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            wr  = int'(bus.ctrl_writeReg);
            ir  = int'(bus.ctrl_issueReg);
            wh  = bus.ctrl_writeEnable && wr != 0;
            acc = bus.ctrl_issueEnable && ir != 0 && exp_ready();
            if (wh) m_reg[wr] <= bus.data_writeReg;
            if (!(wh && acc && wr == ir)) begin
                if (wh) begin
                    if (m_cnt[wr] > 0) m_cnt[wr] <= m_cnt[wr] - 1;
                    else m_err <= 1'b1;
                end
                if (acc) m_cnt[ir] <= m_cnt[ir] + 1;
            end
        end
    end

    task automatic compare();
        int a;
        logic [31:0] ed;
        bit eb;
        for (int k = 0; k < NR; k++) begin
            a = int'(bus.ctrl_readReg[k*AW +: AW]);
            if (a == 0) begin
                ed = 32'h0;
                eb = 1'b0;
            end else begin
                ed = m_reg[a];
                eb = m_cnt[a] != 0;
`ifdef REGFILE_BYPASS_EN
                if (bus.ctrl_writeEnable && int'(bus.ctrl_writeReg) == a) begin
                    ed = bus.data_writeReg;
                    eb = m_cnt[a] > 1;
                end
`endif
            end
            chk($sformatf("rd%0d_data", k), bus.data_readReg[k*DW +: DW], ed);
            chk($sformatf("rd%0d_busy", k), 32'(bus.busy_readReg[k]), 32'(eb));
        end
        chk("issue_ready", 32'(bus.issue_ready), 32'(exp_ready()));
        chk("err_underflow", 32'(bus.err_underflow), 32'(m_err));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) compare();

    task automatic set_in(input bit we, input int wr, input logic [31:0] wd,
                          input bit ie, input int ir, input int a0, input int a1);
        bus.ctrl_writeEnable = we;
        bus.ctrl_writeReg    = AW'(wr);
        bus.data_writeReg    = wd;
        bus.ctrl_issueEnable = ie;
        bus.ctrl_issueReg    = AW'(ir);
        bus.ctrl_readReg     = {AW'(a1), AW'(a0)};
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wr;
        int ir;
        bit we;
        rst_n = 1'b0;
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        #2;
        // Reset state across all registers on both ports.
        for (int r = 0; r < DEPTH; r++) begin
            set_in(1'b0, 0, 32'h0, 1'b0, r, r, DEPTH - 1 - r);
            #1;
            chk("rst_data0", bus.data_readReg[31:0], 32'h0);
            chk("rst_data1", bus.data_readReg[63:32], 32'h0);
            chk("rst_busy", 32'(bus.busy_readReg), 32'h0);
            chk("rst_ready", 32'(bus.issue_ready), 32'h1);
        end
        chk("rst_err", 32'(bus.err_underflow), 32'h0);
        @(negedge clock);
        #2;
        rst_n = 1'b1;

        // Issue r5 then write it back.
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b1, 5, 5, 0);
        #2 chk("t2_busy_pre", 32'(bus.busy_readReg[0]), 32'h0);
        cyc();
        set_in(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 0);
`ifdef REGFILE_BYPASS_EN
        #2 chk("t2_busy_wr", 32'(bus.busy_readReg[0]), 32'h0);
        chk("t2_data_wr", bus.data_readReg[31:0], 32'hDEADBEEF);
`else
        #2 chk("t2_busy_wr", 32'(bus.busy_readReg[0]), 32'h1);
        chk("t2_data_wr", bus.data_readReg[31:0], 32'h0);
`endif
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 5, 0);
        #2 chk("t2_data_after", bus.data_readReg[31:0], 32'hDEADBEEF);
        chk("t2_busy_after", 32'(bus.busy_readReg[0]), 32'h0);

        // Register 0 ignores write and issue.
        set_in(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 0, 0);
        #2 chk("t5_ready", 32'(bus.issue_ready), 32'h1);
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        #2 chk("t5_data", bus.data_readReg[63:0], 64'h0);
        chk("t5_busy", 32'(bus.busy_readReg), 32'h0);
        chk("t5_err", 32'(bus.err_underflow), 32'h0);

        // Saturate r7, drop a 4th issue, then retire.
        set_in(1'b0, 0, 32'h0, 1'b1, 7, 0, 7);
        cyc();
        cyc();
        cyc();
        #2 chk("t3_ready_full", 32'(bus.issue_ready), 32'h0);
        chk("t3_busy_full", 32'(bus.busy_readReg[1]), 32'h1);
        cyc();
        #2 chk("t3_ready_drop", 32'(bus.issue_ready), 32'h0);
        set_in(1'b1, 7, 32'h00000077, 1'b0, 7, 0, 7);
        #2 chk("t3_ready_postwr", 32'(bus.issue_ready), 32'h1);
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 7, 0, 7);
        #2 chk("t3_ready_cnt2", 32'(bus.issue_ready), 32'h1);
        chk("t3_busy_cnt2", 32'(bus.busy_readReg[1]), 32'h1);
        set_in(1'b1, 7, 32'h00000078, 1'b0, 7, 0, 7);
        cyc();
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 7, 0, 7);
        #2 chk("t3_busy_drained", 32'(bus.busy_readReg[1]), 32'h0);
        chk("t3_no_underflow", 32'(bus.err_underflow), 32'h0);

        // Same-cycle write to a pending register seen on port 1.
        set_in(1'b0, 0, 32'h0, 1'b1, 9, 0, 9);
        cyc();
        set_in(1'b1, 9, 32'h12345678, 1'b0, 0, 0, 9);
`ifdef REGFILE_BYPASS_EN
        #2 chk("t6_data_same", bus.data_readReg[63:32], 32'h12345678);
        chk("t6_busy_same", 32'(bus.busy_readReg[1]), 32'h0);
`else
        #2 chk("t6_data_same", bus.data_readReg[63:32], 32'h0);
        chk("t6_busy_same", 32'(bus.busy_readReg[1]), 32'h1);
`endif
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 0, 9);
        #2 chk("t6_data_next", bus.data_readReg[63:32], 32'h12345678);
        chk("t6_busy_next", 32'(bus.busy_readReg[1]), 32'h0);

        // Underflow on r3 is sticky.
        set_in(1'b1, 3, 32'hA5A50003, 1'b0, 0, 3, 0);
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 3, 0);
        #2 chk("t4_err", 32'(bus.err_underflow), 32'h1);
        chk("t4_data", bus.data_readReg[31:0], 32'hA5A50003);
        cyc();
        cyc();
        #2 chk("t4_err_sticky", 32'(bus.err_underflow), 32'h1);

        // Mid-operation reset, then issue+write same register at count 0.
        rst_n = 1'b0;
        #2 chk("mrst_err", 32'(bus.err_underflow), 32'h0);
        chk("mrst_data", bus.data_readReg[31:0], 32'h0);
        @(negedge clock);
        #2;
        rst_n = 1'b1;
        cyc();
        set_in(1'b1, 11, 32'h0000000B, 1'b1, 11, 11, 0);
        #2 chk("simul_ready", 32'(bus.issue_ready), 32'h1);
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 11, 0);
        #2 chk("simul_err", 32'(bus.err_underflow), 32'h0);
        chk("simul_busy", 32'(bus.busy_readReg[0]), 32'h0);
        chk("simul_data", bus.data_readReg[31:0], 32'h0000000B);

        // Randomized traffic concentrated on a few registers to create hazards.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (n % 600 == 599) begin
                rst_n = 1'b0;
                @(negedge clock);
                #2;
                rst_n = 1'b1;
                cyc();
            end
            wr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
            ir = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
            we = (m_cnt[wr] > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 99) == 0);
            set_in(we, wr, $urandom, $urandom_range(0, 9) < 5, ir,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)));
        end
        cyc();
        set_in(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        cyc();
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
